// File: rtl/cp0_core_pkg.sv
// Shared CP0 definitions: register selectors, exception codes and Status/Cause layouts.
package cp0_core_pkg;

  // regsel = {rd[4:0], sel[2:0]}
  localparam logic [7:0] REG_BADVADDR = 8'h40;
  localparam logic [7:0] REG_COUNT    = 8'h48;
  localparam logic [7:0] REG_COMPARE  = 8'h58;
  localparam logic [7:0] REG_STATUS   = 8'h60;
  localparam logic [7:0] REG_CAUSE    = 8'h68;
  localparam logic [7:0] REG_EPC      = 8'h70;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  typedef struct packed {
    logic [8:0] rsvd_31_23;
    logic       bev;
    logic [5:0] rsvd_21_16;
    logic [7:0] im;
    logic [5:0] rsvd_7_2;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_29_16;
    logic [7:0]  ip;
    logic        rsvd_7;
    exc_code_e   exc_code;
    logic [1:0]  rsvd_1_0;
  } cause_t;

  // Restart address: a fault in a delay slot resumes at the branch.
  function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and sticky timer-interrupt flag.
module cp0_timer
  import cp0_core_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ti_q, ti_d;
  logic          tick;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (count_we_i) begin
      count_d = wdata_i;
      presc_d = '0;
    end
    // Writing Compare acknowledges the timer, even against a same-edge match.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      compare_q <= '0;
      presc_q   <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_core.sv
// MIPS-style CP0: mfc0/mtc0 access, exception entry/eret, interrupt request generation.
module cp0_core
  import cp0_core_pkg::*;
#(
  parameter int unsigned N_HW_INT   = 5,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mf_valid,
  input  logic [7:0]          mf_regsel,
  output logic [31:0]         rdata,
  input  logic                mt_valid,
  input  logic [7:0]          mt_regsel,
  input  logic [31:0]         mt_wdata,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic                exc_badv_valid,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  input  logic [N_HW_INT-1:0] hw_int,
  output logic                int_req,
  output logic [31:0]         status,
  output logic [31:0]         cause,
  output logic [31:0]         epc,
  output logic [31:0]         exc_vector,
  output logic                eret_adel,
  output logic [31:0]         eret_badvaddr
);

  status_t     status_q, status_d;
  logic        bd_q, bd_d;
  exc_code_e   exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  ip_hw_q, ip_hw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        mt_fire, eret_fire;
  logic [31:0] count_w, compare_w;
  logic        ti_w;
  cause_t      cause_w;

  // An exception in the same cycle squashes the mtc0 and the eret.
  assign mt_fire   = mt_valid & ~exc_valid;
  assign eret_fire = eret & ~exc_valid;

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk_i       (clk),
    .rst_i       (reset),
    .count_we_i  (mt_fire && (mt_regsel == REG_COUNT)),
    .compare_we_i(mt_fire && (mt_regsel == REG_COMPARE)),
    .wdata_i     (mt_wdata),
    .count_o     (count_w),
    .compare_o   (compare_w),
    .ti_o        (ti_w)
  );

  always_comb begin
    ip_hw_d               = '0;
    ip_hw_d[N_HW_INT-1:0] = hw_int;
  end

  always_comb begin
    cause_w          = '0;
    cause_w.bd       = bd_q;
    cause_w.ti       = ti_w;
    cause_w.ip       = {ti_w, ip_hw_q, ip_sw_q};
    cause_w.exc_code = exc_code_q;
  end

  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (exc_valid) begin
      if (!status_q.exl) begin
        epc_d = restart_pc(exc_pc, exc_bd);
        bd_d  = exc_bd;
      end
      exc_code_d   = exc_code_e'(exc_code);
      status_d.exl = 1'b1;
      if (exc_badv_valid) begin
        badvaddr_d = exc_badvaddr;
      end
    end else begin
      if (mt_fire) begin
        case (mt_regsel)
          REG_STATUS: begin
            status_d.im  = mt_wdata[15:8];
            status_d.exl = mt_wdata[1];
            status_d.ie  = mt_wdata[0];
          end
          REG_CAUSE: ip_sw_d = mt_wdata[9:8];
          REG_EPC:   epc_d   = mt_wdata;
          default: ;
        endcase
      end
      if (eret_fire) begin
        status_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q   <= status_t'(STATUS_RESET);
      bd_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (mf_valid) begin
      case (mf_regsel)
        REG_BADVADDR: rdata = badvaddr_q;
        REG_COUNT:    rdata = count_w;
        REG_COMPARE:  rdata = compare_w;
        REG_STATUS:   rdata = status_q;
        REG_CAUSE:    rdata = cause_w;
        REG_EPC:      rdata = epc_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign int_req       = status_q.ie & ~status_q.exl & (|(cause_w.ip & status_q.im));
  assign status        = status_q;
  assign cause         = cause_w;
  assign epc           = epc_q;
  assign exc_vector    = EXC_VECTOR;
  assign eret_adel     = eret & (epc_q[1:0] != 2'b00);
  assign eret_badvaddr = eret_adel ? epc_q : 32'd0;

endmodule

// File: tb/tb_cp0_core.sv
// Directed bench for cp0_core with immediate-assertion checks at each step.
module tb_cp0_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        mf_valid;
  logic [7:0]  mf_regsel;
  logic [31:0] rdata;
  logic        mt_valid;
  logic [7:0]  mt_regsel;
  logic [31:0] mt_wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badv_valid;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [4:0]  hw_int;
  logic        int_req;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] exc_vector;
  logic        eret_adel;
  logic [31:0] eret_badvaddr;

  int checks = 0;
  int fails  = 0;

  cp0_core #(
    .N_HW_INT  (5),
    .COUNT_DIV (2),
    .EXC_VECTOR(32'hBFC0_0380)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mf_valid      (mf_valid),
    .mf_regsel     (mf_regsel),
    .rdata         (rdata),
    .mt_valid      (mt_valid),
    .mt_regsel     (mt_regsel),
    .mt_wdata      (mt_wdata),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code),
    .exc_pc        (exc_pc),
    .exc_bd        (exc_bd),
    .exc_badv_valid(exc_badv_valid),
    .exc_badvaddr  (exc_badvaddr),
    .eret          (eret),
    .hw_int        (hw_int),
    .int_req       (int_req),
    .status        (status),
    .cause         (cause),
    .epc           (epc),
    .exc_vector    (exc_vector),
    .eret_adel     (eret_adel),
    .eret_badvaddr (eret_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mt(input logic [7:0] sel, input logic [31:0] d);
    mt_valid  = 1'b1;
    mt_regsel = sel;
    mt_wdata  = d;
    step();
    mt_valid  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] sel, output logic [31:0] v);
    mf_valid  = 1'b1;
    mf_regsel = sel;
    #1;
    v = rdata;
    mf_valid  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        found;

    reset = 1'b1;
    mf_valid = 0; mf_regsel = 0; mt_valid = 0; mt_regsel = 0; mt_wdata = 0;
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    exc_badv_valid = 0; exc_badvaddr = 0; eret = 0; hw_int = 0;
    #3;
    check("rst_status", status, 32'h0040_0000);
    check("rst_cause", cause, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("exc_vector", exc_vector, 32'hBFC0_0380);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rd(8'h48, v);
    check("count_after_10", v, 32'd5);
    check("status_idle", status, 32'h0040_0000);
    // Count==Compare==0 right after reset raises the timer flag.
    check("cause_ti_from_reset", cause, 32'h4000_8000);
    mf_regsel = 8'h48;
    #1;
    check("rdata_no_valid", rdata, 32'h0);

    mt(8'h58, 32'd8);
    check("ti_cleared_by_compare", {31'd0, cause[30]}, 32'd0);
    mt(8'h60, 32'h0000_8001);
    check("status_write", status, 32'h0040_8001);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(8'h48, v);
      if (v == 32'd8) found = 1'b1;
      else step();
    end
    check("count_reaches_8", {31'd0, found}, 32'd1);
    check("ti_not_yet", {31'd0, cause[30]}, 32'd0);
    step();
    check("ti_set", {31'd0, cause[30]}, 32'd1);
    check("ip7_set", {31'd0, cause[15]}, 32'd1);
    check("int_req_timer", {31'd0, int_req}, 32'd1);
    // Count still equals Compare on this edge, so the clear must win.
    mt(8'h58, 32'd20);
    check("ti_clear_wins", {31'd0, cause[30]}, 32'd0);
    check("int_req_cleared", {31'd0, int_req}, 32'd0);

    exc_valid = 1; exc_pc = 32'hBFC0_0100; exc_bd = 1; exc_code = 5'd4;
    exc_badv_valid = 1; exc_badvaddr = 32'h1234_0001;
    step();
    exc_valid = 0; exc_badv_valid = 0;
    check("exc_epc_bd", epc, 32'hBFC0_00FC);
    check("exc_cause_bd", {31'd0, cause[31]}, 32'd1);
    check("exc_code_4", {27'd0, cause[6:2]}, 32'd4);
    check("exc_exl", {31'd0, status[1]}, 32'd1);
    rd(8'h40, v);
    check("badvaddr", v, 32'h1234_0001);

    exc_valid = 1; exc_pc = 32'h8000_0000; exc_bd = 0; exc_code = 5'd12;
    mt_valid = 1; mt_regsel = 8'h70; mt_wdata = 32'h0;
    step();
    exc_valid = 0; mt_valid = 0;
    check("nested_epc_kept", epc, 32'hBFC0_00FC);
    check("nested_code_12", {27'd0, cause[6:2]}, 32'd12);
    check("nested_bd_kept", {31'd0, cause[31]}, 32'd1);
    rd(8'h40, v);
    check("badv_kept", v, 32'h1234_0001);

    mt(8'h70, 32'h8000_0002);
    check("epc_write", epc, 32'h8000_0002);
    check("adel_idle", {31'd0, eret_adel}, 32'd0);
    eret = 1;
    #1;
    check("eret_adel", {31'd0, eret_adel}, 32'd1);
    check("eret_badv", eret_badvaddr, 32'h8000_0002);
    @(negedge clk);
    eret = 0;
    check("eret_exl_clear", {31'd0, status[1]}, 32'd0);

    mt(8'h60, 32'hFFFF_FFFF);
    check("status_mask", status, 32'h0040_FF03);
    hw_int = 5'b10101;
    mt(8'h68, 32'hFFFF_FFFF);
    check("cause_ip_hw_sw", cause & 32'h0000_7F00, 32'h0000_5700);
    check("int_req_exl_block", {31'd0, int_req}, 32'd0);
    mt(8'h60, 32'h0000_FF01);
    check("int_req_hw", {31'd0, int_req}, 32'd1);
    rd(8'h50, v);
    check("unknown_regsel", v, 32'h0);

    mt(8'h48, 32'hFFFF_FFFF);
    rd(8'h48, v);
    check("count_wr_max", v, 32'hFFFF_FFFF);
    step();
    rd(8'h48, v);
    check("count_max_hold", v, 32'hFFFF_FFFF);
    step();
    rd(8'h48, v);
    check("count_wrap", v, 32'h0);
    step();
    mt(8'h48, 32'd7);
    rd(8'h48, v);
    check("count_wr_override", v, 32'd7);
    step();
    rd(8'h48, v);
    check("count_presc0_hold", v, 32'd7);
    step();
    rd(8'h48, v);
    check("count_presc0_inc", v, 32'd8);
    mt(8'h48, 32'd100);
    step();
    rd(8'h48, v);
    check("presc_reset_hold", v, 32'd100);
    step();
    rd(8'h48, v);
    check("presc_reset_inc", v, 32'd101);

    hw_int = 0;
    exc_valid = 1; exc_pc = 32'h1000_0000; exc_bd = 0; exc_code = 5'd8;
    mt_valid = 1; mt_regsel = 8'h70; mt_wdata = 32'h5555_5555;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_status", status, 32'h0040_0000);
    check("midrst_epc", epc, 32'h0);
    check("midrst_cause", cause, 32'h0);
    @(negedge clk);
    exc_valid = 0; mt_valid = 0;
    reset = 1'b0;
    step();
    check("post_rst_epc", epc, 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
